// File: rtl/uat_arbiter.sv
// uat_arbiter -- round-robin packet arbiter sharing one uat transmitter.
//
// Grants one requester per packet (round-robin from ptr), optionally emits a
// source-ID header byte (8'hA0 | id), then forwards the owner's bytes to the
// uat one at a time, holding the grant until req_last. A granted requester
// that idles for TIMEOUT cycles in DATA has its packet aborted.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req_valid    per-requester byte valid            [N_REQ]
//   req_data     per-requester byte, lane i at [8*i+7:8*i]
//   req_last     byte is last of packet              [N_REQ]
//   req_ready    byte accepted on valid & ready      [N_REQ]
//   tx_data      byte to uat
//   tx_valid     one-cycle strobe to uat
//   tx_busy      uat busy
//   grant        one-hot current owner, zero when idle
//   active       packet in progress
//   err_timeout  one-cycle pulse on packet abort
module uat_arbiter #(
  parameter int N_REQ     = 4,
  parameter bit HEADER_EN = 1'b1,
  parameter int TIMEOUT   = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_busy,
  output logic [N_REQ-1:0]   grant,
  output logic               active,
  output logic               err_timeout
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] g;
  logic [19:0]   tmo_cnt;

  // tx_valid is registered, so gating on it guarantees no back-to-back strobes
  // and covers the cycle before the uat raises busy.
  logic tx_free;
  assign tx_free = !tx_busy && !tx_valid;
  assign active  = (state != S_IDLE);

  // Round-robin search: first valid index at or above ptr, wrapping.
  logic          hit;
  logic [PW-1:0] sel;
  int            idx;
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        sel = PW'(idx);
      end
    end
  end

  logic [N_REQ-1:0] sel_oh;
  always_comb begin
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
  end

  logic [PW-1:0] ptr_nxt;
  assign ptr_nxt = (int'(g) + 1 >= N_REQ) ? '0 : g + PW'(1);

  logic [3:0] id4;
  assign id4 = 4'(g);

  logic [7:0] data_g;
  assign data_g = req_data[int'(g)*8 +: 8];

  always_comb begin
    req_ready = '0;
    if (state == S_DATA && tx_free) req_ready[g] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      g           <= '0;
      grant       <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      err_timeout <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      tx_valid    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hit) begin
            g       <= sel;
            grant   <= sel_oh;
            tmo_cnt <= '0;
            state   <= HEADER_EN ? S_HDR : S_DATA;
          end
        end
        S_HDR: begin
          if (tx_free) begin
            tx_data  <= 8'hA0 | {4'h0, id4};
            tx_valid <= 1'b1;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (req_valid[g]) begin
            // Valid but uat not free: backpressure, timer holds.
            if (tx_free) begin
              tx_data  <= data_g;
              tx_valid <= 1'b1;
              tmo_cnt  <= '0;
              if (req_last[g]) begin
                state <= S_IDLE;
                grant <= '0;
                ptr   <= ptr_nxt;
              end
            end
          end else if (tmo_cnt == 20'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            grant       <= '0;
            ptr         <= ptr_nxt;
            state       <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 20'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uat_arbiter.sv
// tb_uat_arbiter -- directed bench for uat_arbiter.
// dut : N_REQ=4, HEADER_EN=1, TIMEOUT=50
// dut2: N_REQ=1, HEADER_EN=0
// A small uat model holds busy for 10 cycles after each strobe. Requesters are
// byte queues; the bench logs every tx byte and compares against hand-computed
// sequences.
module tb_uat_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- dut (4 requesters, header, short timeout)
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_last  = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic [3:0]  grant;
  logic        active;
  logic        err_timeout;

  uat_arbiter #(.N_REQ(4), .HEADER_EN(1'b1), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .grant(grant), .active(active), .err_timeout(err_timeout)
  );

  // ---------------- dut2 (single requester, no header)
  logic [0:0] r2_valid = '0;
  logic [7:0] r2_data  = '0;
  logic [0:0] r2_last  = '0;
  logic [0:0] r2_ready;
  logic [7:0] tx2_data;
  logic       tx2_valid;
  logic       tx2_busy;
  logic [0:0] grant2;
  logic       active2;
  logic       err2;

  uat_arbiter #(.N_REQ(1), .HEADER_EN(1'b0), .TIMEOUT(50)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(r2_valid), .req_data(r2_data), .req_last(r2_last),
    .req_ready(r2_ready),
    .tx_data(tx2_data), .tx_valid(tx2_valid), .tx_busy(tx2_busy),
    .grant(grant2), .active(active2), .err_timeout(err2)
  );

  // ---------------- uat busy models (not reset: a byte in flight completes)
  logic [4:0] busy_cnt  = '0;
  logic [4:0] busy2_cnt = '0;
  assign tx_busy  = (busy_cnt != 0);
  assign tx2_busy = (busy2_cnt != 0);
  always @(posedge clk) begin
    if (tx_valid) busy_cnt <= 5'd10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 5'd1;
    if (tx2_valid) busy2_cnt <= 5'd10;
    else if (busy2_cnt != 0) busy2_cnt <= busy2_cnt - 5'd1;
  end

  // ---------------- requester queues, accept capture, cycle counter
  logic [8:0] q [4][$];
  logic [8:0] q2 [$];
  logic [3:0] acc  = '0;
  logic       acc2 = 1'b0;
  int         cyc  = 0;
  int         n_acc2 = 0;
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    acc  <= req_valid & req_ready;
    acc2 <= r2_valid[0] & r2_ready[0];
    if (req_valid[2] && req_ready[2]) n_acc2 <= n_acc2 + 1;
  end

  // ---------------- monitors
  logic [7:0] log_q [$];
  logic [7:0] log2_q [$];
  int  viol = 0, viol2 = 0;
  logic pv = 1'b0, pb = 1'b0, pv2 = 1'b0, pb2 = 1'b0;
  int  acc0_cyc = 0, err_cyc = 0, n_err = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (acc[i] && q[i].size() > 0) begin
        void'(q[i].pop_front());
        if (i == 0) acc0_cyc = cyc;
      end
      if (q[i].size() > 0) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = q[i][0][7:0];
        req_last[i]       = q[i][0][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
    if (acc2 && q2.size() > 0) void'(q2.pop_front());
    if (q2.size() > 0) begin
      r2_valid[0] = 1'b1;
      r2_data     = q2[0][7:0];
      r2_last[0]  = q2[0][8];
    end else begin
      r2_valid[0] = 1'b0;
      r2_data     = 8'h00;
      r2_last[0]  = 1'b0;
    end
    // strobe must only follow a cycle with busy low and no strobe
    if (tx_valid) log_q.push_back(tx_data);
    if (tx_valid && (pv || pb)) viol++;
    pv = tx_valid; pb = tx_busy;
    if (tx2_valid) log2_q.push_back(tx2_data);
    if (tx2_valid && (pv2 || pb2)) viol2++;
    pv2 = tx2_valid; pb2 = tx2_busy;
    if (err_timeout) begin
      err_cyc = cyc;
      n_err++;
    end
  end

  // ---------------- checking
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    q[r].push_back({l, b});
  endtask

  task automatic wait_log(input int n, input string tag);
    int t;
    t = 0;
    while (log_q.size() < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, log_q.size(), n);
  endtask

  task automatic chk_log(input string tag, input int base, input logic [7:0] e0,
                         input logic [7:0] e1, input logic [7:0] e2, input int n);
    logic [7:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    for (int k = 0; k < n; k++)
      chk($sformatf("%s_b%0d", tag, k), {24'h0, log_q[base+k]}, {24'h0, e[k]});
  endtask

  initial begin
    int t, nerr0, a0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant",  grant,       4'h0);
    chk("rst_active", active,      1'b0);
    chk("rst_txv",    tx_valid,    1'b0);
    chk("rst_txd",    tx_data,     8'h00);
    chk("rst_err",    err_timeout, 1'b0);
    chk("rst_ready",  req_ready,   4'h0);
    @(posedge clk); #2 rst = 1'b0;

    // req0 and req3 together, ptr=0: req0 packet then req3, no interleave
    @(posedge clk); #1;
    push(0, 8'h10, 1'b0); push(0, 8'h20, 1'b1); push(3, 8'h30, 1'b1);
    wait_log(5, "rr_cnt");
    chk_log("rr_a", 0, 8'hA0, 8'h10, 8'h20, 3);
    chk_log("rr_b", 3, 8'hA3, 8'h30, 8'h00, 2);

    // req1 packet {11,22,last}
    @(posedge clk); #1;
    push(1, 8'h11, 1'b0); push(1, 8'h22, 1'b1);
    wait_log(6, "p1_hdr");
    chk("p1_grant", grant, 4'b0010);
    wait_log(8, "p1_cnt");
    chk_log("p1", 5, 8'hA1, 8'h11, 8'h22, 3);
    repeat (15) @(negedge clk);
    chk("p1_grant_end", grant, 4'h0);
    chk("p1_active_end", active, 1'b0);

    // ptr=2 now: req3 must win over req0
    @(posedge clk); #1;
    push(0, 8'h01, 1'b1); push(3, 8'h03, 1'b0); push(3, 8'h04, 1'b1);
    wait_log(13, "ptr2_cnt");
    chk_log("ptr2_a", 8, 8'hA3, 8'h03, 8'h04, 3);
    chk_log("ptr2_b", 11, 8'hA0, 8'h01, 8'h00, 2);

    // req2 3-byte packet under uat backpressure
    repeat (15) @(posedge clk); #1;
    a0 = n_acc2;
    push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b0); push(2, 8'hC3, 1'b1);
    wait_log(17, "bp_cnt");
    chk_log("bp_a", 13, 8'hA2, 8'hC1, 8'hC2, 3);
    chk_log("bp_b", 16, 8'hC3, 8'h00, 8'h00, 1);
    repeat (5) @(negedge clk);
    chk("bp_accepts", n_acc2 - a0, 3);

    // timeout: req0 sends one byte without last then drops valid
    repeat (15) @(posedge clk); #1;
    nerr0 = n_err;
    push(0, 8'hE1, 1'b0);
    t = 0;
    while (n_err == nerr0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("tmo_seen",  n_err - nerr0, 1);
    chk("tmo_gap",   err_cyc - acc0_cyc, 50);
    chk("tmo_grant", grant, 4'h0);
    chk("tmo_active", active, 1'b0);
    @(negedge clk);
    chk("tmo_pulse", err_timeout, 1'b0);
    chk_log("tmo", 17, 8'hA0, 8'hE1, 8'h00, 2);
    // ptr=1 after abort: req1 beats req0
    @(posedge clk); #1;
    push(0, 8'hB0, 1'b1); push(1, 8'hB1, 1'b1);
    wait_log(23, "ptr1_cnt");
    chk_log("ptr1_a", 19, 8'hA1, 8'hB1, 8'h00, 2);
    chk_log("ptr1_b", 21, 8'hA0, 8'hB0, 8'h00, 2);

    // reset mid-DATA, resume after uat byte drains
    repeat (15) @(posedge clk); #1;
    push(2, 8'h91, 1'b0); push(2, 8'h92, 1'b0); push(2, 8'h93, 1'b1);
    wait_log(25, "mid_cnt");
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("mid_grant",  grant,     4'h0);
    chk("mid_active", active,    1'b0);
    chk("mid_txv",    tx_valid,  1'b0);
    chk("mid_txd",    tx_data,   8'h00);
    chk("mid_ready",  req_ready, 4'h0);
    q[2].delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    push(1, 8'h77, 1'b1);
    wait_log(27, "post_cnt");
    chk_log("post", 25, 8'hA1, 8'h77, 8'h00, 2);

    // single requester, no header
    @(posedge clk); #1;
    q2.push_back({1'b1, 8'h55});
    t = 0;
    while (log2_q.size() < 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("n1_cnt", log2_q.size(), 1);
    chk("n1_byte", {24'h0, log2_q[0]}, 32'h55);
    repeat (20) @(negedge clk);
    chk("n1_cnt_end", log2_q.size(), 1);
    chk("n1_grant_end", grant2, 1'b0);
    chk("n1_active_end", active2, 1'b0);
    chk("n1_err", err2, 1'b0);

    chk("txv_spacing", viol, 0);
    chk("txv2_spacing", viol2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
